// File: rtl/seq_burst_ctrl_if.sv
// seq_burst_ctrl_if: command, generator and output-beat signals of the burst scheduler.
// Optional SEQ_BURST_CTRL_CSUM_EN adds the csum signal.
`timescale 1ns/1ps
`default_nettype none

interface seq_burst_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4,
  parameter int REP_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [GAP_W-1:0]  cmd_gap;
  logic [REP_W-1:0]  cmd_reps;
  logic              abort;
  logic              gen_enable;
  logic [DATA_W-1:0] gen_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              done;
  logic              err;
`ifdef SEQ_BURST_CTRL_CSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  modport slave (
    input  cmd_valid, cmd_len, cmd_gap, cmd_reps, abort, gen_data, out_ready,
`ifdef SEQ_BURST_CTRL_CSUM_EN
    output csum,
`endif
    output cmd_ready, gen_enable, out_valid, out_data, busy, done, err
  );

  modport master (
    output cmd_valid, cmd_len, cmd_gap, cmd_reps, abort, gen_data, out_ready,
`ifdef SEQ_BURST_CTRL_CSUM_EN
    input  csum,
`endif
    input  cmd_ready, gen_enable, out_valid, out_data, busy, done, err
  );
endinterface

`default_nettype wire

// File: rtl/seq_burst_ctrl.sv
// seq_burst_ctrl: sequences generator enable into bursts and forwards beats through a
// one-deep valid/ready register. Optional SEQ_BURST_CTRL_CSUM_EN adds an XOR checksum. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module seq_burst_ctrl #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int GAP_W  = 4,
  parameter int REP_W  = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  seq_burst_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_GAP   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat_cnt;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [REP_W-1:0]  r_reps;
  logic [REP_W-1:0]  r_rep_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_illegal;
  logic              w_abort;
  logic              w_gen_enable;
  logic              w_flush_done;
  logic              w_drain;
  logic              w_last_beat;
  logic              w_more_reps;
  logic              w_gap_end;

  assign w_drain     = r_out_valid && bus.out_ready;
  assign w_last_beat = (r_beat_cnt == (r_len - LEN_W'(1)));
  assign w_more_reps = (r_rep_cnt != r_reps);
  assign w_gap_end   = (r_gap_cnt == (r_gap - GAP_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_illegal    = 1'b0;
    w_abort      = 1'b0;
    w_gen_enable = 1'b0;
    w_flush_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len != '0) begin
            w_accept = 1'b1;
            w_next   = S_RUN;
          end else begin
            w_illegal = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else begin
          // A beat is taken only when the output register is free or draining this edge.
          w_gen_enable = !r_out_valid || bus.out_ready;
          if (w_gen_enable && w_last_beat) begin
            if (w_more_reps) begin
              w_next = (r_gap != '0) ? S_GAP : S_RUN;
            end else begin
              w_next = S_FLUSH;
            end
          end
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (w_gap_end) begin
          w_next = S_RUN;
        end
      end
      S_FLUSH: begin
        if (bus.abort) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (w_drain) begin
          w_flush_done = 1'b1;
          w_next       = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len       <= '0;
      r_gap       <= '0;
      r_reps      <= '0;
      r_beat_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_rep_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_flush_done || w_illegal;
      r_err  <= w_illegal || w_abort;

      if (w_accept) begin
        r_len      <= bus.cmd_len;
        r_gap      <= bus.cmd_gap;
        r_reps     <= bus.cmd_reps;
        r_beat_cnt <= '0;
        r_gap_cnt  <= '0;
        r_rep_cnt  <= '0;
      end else if (w_gen_enable) begin
        if (w_last_beat) begin
          r_beat_cnt <= '0;
          r_gap_cnt  <= '0;
          if (w_more_reps) begin
            r_rep_cnt <= r_rep_cnt + REP_W'(1);
          end
        end else begin
          r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        end
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
      end

      // A capture on the same edge as a drain keeps the register full.
      if (w_abort) begin
        r_out_valid <= 1'b0;
      end else if (w_gen_enable) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.gen_data;
      end else if (w_drain) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_BURST_CTRL_CSUM_EN
  logic [DATA_W-1:0] r_csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= '0;
    end else if (w_drain) begin
      r_csum <= r_csum ^ r_out_data;
    end
  end

  assign bus.csum = r_csum;
`endif

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.gen_enable = w_gen_enable;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: doc/seq_burst_ctrl.md
# seq_burst_ctrl

Burst scheduler that sequences the 8-bit `SequenceGenerator`. It accepts a command (burst length, inter-burst gap, repeat count) and drives the generator's `enable` for exactly the programmed number of beats per burst. It forwards each generated byte through a one-deep valid/ready output register, stalling the generator under backpressure. It sits between the test/control logic and the generator, replacing hand-timed `enable` stimulus.

## Interface
Parameters:
- `DATA_W`, 8: generator data width.
- `LEN_W`, 8: burst-length field width.
- `GAP_W`, 4: gap field width.
- `REP_W`, 4: repeat field width.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_len` in LEN_W: beats per burst; 0 is illegal.
- `cmd_gap` in GAP_W: idle cycles between bursts.
- `cmd_reps` in REP_W: bursts minus one (0 means 1 burst).
- `abort` in 1: synchronous cancel.
- `gen_enable` out 1: to generator `enable`.
- `gen_data` in DATA_W: from generator `data`.
- `out_valid` out 1, `out_ready` in 1, `out_data` out DATA_W: output beat handshake.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle error pulse.

## Operation
- Generator contract: a beat is the `gen_data` value sampled at a rising edge where `gen_enable`=1; the generator advances on that same edge.
- States: IDLE, RUN, GAP, FLUSH.
- IDLE:
  - `cmd_ready`=1. On `cmd_valid` with `cmd_len`≠0, latch len/gap/reps, reset counters, and go to RUN.
  - On `cmd_len`=0, stay in IDLE and pulse `err` and `done` next cycle.
- RUN:
  - `gen_enable` = !`out_valid` || `out_ready` (combinational).
  - Each enabled edge captures `gen_data` into `out_data`, sets `out_valid`, and increments the beat count.
  - On the last beat of a burst: if bursts remain, go to GAP when gap>0 or start RUN again with count 0 when gap=0. Otherwise go to FLUSH.
- GAP: `gen_enable`=0 for exactly `cmd_gap` cycles, then RUN.
- FLUSH: `gen_enable`=0. On the edge that handshakes the final beat, go to IDLE and register `done`=1 for one cycle.
- Output register: `out_valid` clears on an `out_valid`&&`out_ready` edge unless a new beat is captured on the same edge.
- Abort: any non-IDLE state → IDLE on the next edge. `out_valid` clears, and `err` pulses for one cycle with no `done`. Abort in IDLE is ignored.
- Counters: beat counter is LEN_W and compares with the latched len. Repeat counter is REP_W and counts up to the latched reps. Gap counter is GAP_W. No wrap occurs in legal operation.

## Timing
- Reset values: `cmd_ready`=1, `gen_enable`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `err`=0; state is IDLE.
- Command accepted at edge N: `busy`=1 and `gen_enable` may be 1 in cycle N+1.
- First beat captured at edge N+1 and visible on `out_data` in cycle N+2.
- Latency: capture edge to `out_valid`=1 is 1 cycle.
- With `out_ready` held at 1: `gen_enable` is high for exactly `cmd_len` consecutive cycles per burst, low for exactly `cmd_gap` cycles between bursts, and has no bubbles.
- Completion: after the final handshake edge, `done`=1, `busy`=0 and `cmd_ready`=1 in the same cycle. A new command may be accepted in that cycle.
- Backpressure: when `out_ready`=0 and `out_valid`=1, `gen_enable`=0. No beat is lost or duplicated.
- Reset mid-burst: everything returns to reset values immediately, and no `done` is raised.

## Configuration
- `SEQ_BURST_CTRL_CSUM_EN` defined: adds output `csum` [DATA_W-1:0]. It is the XOR of every `out_data` handshaked since the last command acceptance, cleared to 0 on acceptance and on reset, and stable after `done`.
- Not defined: no `csum` port and no checksum logic.

## Test plan
- Reset mid-run: assert `reset` during the third beat → all outputs at reset values within the same cycle, `gen_enable`=0, and after release `cmd_ready`=1 with no `done`.
- Single burst: len=4, gap=0, reps=0, `out_ready`=1 → `gen_enable` high for 4 cycles, 4 consecutive generator values forwarded, `done` pulses once 1 cycle after the 4th handshake.
- Repeats with gap: len=3, gap=2, reps=2 → enable pattern 3 high, 2 low, 3 high, 2 low, 3 high; 9 beats forwarded; one `done`.
- Backpressure: len=5, `out_ready` toggling 1,0,0,1,… → `gen_enable` low whenever the output is full and not drained; the forwarded sequence has no gaps or repeats.
- Illegal and abort: `cmd_len`=0 → `err`=`done`=1 for one cycle with no enable. `abort` during a gap → IDLE next cycle, `out_valid`=0, `err` pulse, no `done`.
- With `SEQ_BURST_CTRL_CSUM_EN`: len=2 with beats 8'h05 and 8'h0C → `csum`=8'h09 at `done`, and 0 after the next command is accepted.
